exc_sequencer: RTL and testbench

Exception-entry/return sequencer for the CP0 block: it turns the CP0 pending-exception flag (`exl`) into an ordered sequence that takes the processor into the handler and back. It waits for an instruction boundary, writes the return address to EPC (reg 14), masks interrupts in Status (reg 12), and redirects the PC to the vector selected by `iv`. On `eret` it reverses the sequence. It sits between CP0, the control unit and the PC register, and drives CP0's single write port during its own write states.

---
 rtl/cp0_pkg.sv | 76 +++++++
 rtl/exc_prio_enc.sv | 28 ++
 rtl/exc_sequencer.sv | 138 +++++++++++++
 tb/tb_exc_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared CP0 definitions: exception sequencer state encoding,
//                CP0 register indices, exception codes, default vectors and
//                the state-to-control decode used by the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package cp0_pkg;

  // CP0 register indices
  localparam logic [4:0] C_REG_STATUS = 5'd12;
  localparam logic [4:0] C_REG_CAUSE  = 5'd13;
  localparam logic [4:0] C_REG_EPC    = 5'd14;

  // Exception codes
  localparam logic [4:0] C_EXC_INT     = 5'd0;
  localparam logic [4:0] C_EXC_DEFAULT = 5'd10;
  localparam logic [4:0] C_EXC_TRAP    = 5'd13;

  // Default handler vectors
  localparam logic [31:0] C_DEF_VEC0 = 32'h0000_0180;
  localparam logic [31:0] C_DEF_VEC1 = 32'h0000_0200;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_SAVE    = 3'd2,
    ST_MASK    = 3'd3,
    ST_VECTOR  = 3'd4,
    ST_HANDLER = 3'd5,
    ST_RESTORE = 3'd6,
    ST_RETURN  = 3'd7
  } state_t;

  // Control outputs that depend on state alone (registered in the sequencer)
  typedef struct packed {
    logic       hold;
    logic       cp0_we;
    logic [4:0] cp0_addr;
    logic       pc_load;
    logic       in_handler;
  } seq_ctrl_t;

  function automatic seq_ctrl_t state_ctrl(input state_t st);
    seq_ctrl_t c;
    c = '0;
    case (st)
      ST_DRAIN: begin
        c.hold = 1'b1;
      end
      ST_SAVE: begin
        c.hold     = 1'b1;
        c.cp0_we   = 1'b1;
        c.cp0_addr = C_REG_EPC;
      end
      ST_MASK, ST_RESTORE: begin
        c.hold     = 1'b1;
        c.cp0_we   = 1'b1;
        c.cp0_addr = C_REG_STATUS;
      end
      ST_VECTOR, ST_RETURN: begin
        c.pc_load = 1'b1;
      end
      ST_HANDLER: begin
        c.in_handler = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exc_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : exc_prio_enc
//  Description : Combinational exception-code priority encoder.
//                Interrupts (cause[7:2]) beat traps (cause[1:0]); with
//                nothing pending the default code is returned.
//  Ports       : cause [7:0] in  - CP0 Cause[15:8]
//                code  [4:0] out - encoded exception code
//  Revision    : 1.0  initial release
// ============================================================================
module exc_prio_enc
  import cp0_pkg::*;
(
  input  logic [7:0] cause,
  output logic [4:0] code
);

  always_comb begin
    code = C_EXC_DEFAULT;
    if (|cause[7:2]) begin
      code = C_EXC_INT;
    end else if (|cause[1:0]) begin
      code = C_EXC_TRAP;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exc_sequencer
//  Description : Exception entry/return sequencer. Waits for an instruction
//                boundary, saves the return address to EPC, masks interrupts
//                in Status, redirects the PC to the handler vector, and on
//                ERET restores Status and jumps back to EPC.
//  Ports       : clk, rst (async, active-low)
//                exl, iv, cause[7:0], status[31:0], epc[31:0]  - from CP0
//                pcp4[31:0], instr_done, eret                  - from core
//                hold                                          - stall
//                cp0_we, cp0_addr[4:0], cp0_wd[31:0]           - CP0 write
//                pc_load, pc_target[31:0]                      - PC redirect
//                in_handler, exc_code[4:0]                     - status
//  Revision    : 1.0  initial release
// ============================================================================
module exc_sequencer
  import cp0_pkg::*;
#(
  parameter logic [31:0] VEC0 = C_DEF_VEC0,
  parameter logic [31:0] VEC1 = C_DEF_VEC1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exl,
  input  logic        iv,
  input  logic [7:0]  cause,
  input  logic [31:0] status,
  input  logic [31:0] epc,
  input  logic [31:0] pcp4,
  input  logic        instr_done,
  input  logic        eret,
  output logic        hold,
  output logic        cp0_we,
  output logic [4:0]  cp0_addr,
  output logic [31:0] cp0_wd,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        in_handler,
  output logic [4:0]  exc_code
);

  state_t      r_state;
  state_t      w_next;
  seq_ctrl_t   r_ctrl;
  logic [31:0] r_epc_q;
  logic [4:0]  r_code;
  logic [4:0]  w_code;
  logic        w_latch;

  exc_prio_enc u_prio (
    .cause (cause),
    .code  (w_code)
  );

  // Next-state logic; w_latch marks the boundary where EPC and code are captured
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (exl) begin
          if (instr_done) begin
            w_latch = 1'b1;
            w_next  = ST_SAVE;
          end else begin
            w_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (instr_done) begin
          w_latch = 1'b1;
          w_next  = ST_SAVE;
        end else if (!exl) begin
          w_next = ST_IDLE;
        end
      end
      ST_SAVE:    w_next = ST_MASK;
      ST_MASK:    w_next = ST_VECTOR;
      ST_VECTOR:  w_next = ST_HANDLER;
      ST_HANDLER: begin
        // exl deliberately ignored here: no nested exceptions
        if (eret && instr_done) begin
          w_next = ST_RESTORE;
        end
      end
      ST_RESTORE: w_next = ST_RETURN;
      ST_RETURN:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State register with the control outputs pre-decoded from the next state,
  // so they appear registered in the same cycle the state is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ctrl  <= '0;
      r_epc_q <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next);
      if (w_latch) begin
        r_epc_q <= pcp4;
        r_code  <= w_code;
      end
    end
  end

  // Data paths: Status is stable while hold is high (core writes blocked),
  // and the redirect targets must track iv/epc in the cycle they are used.
  always_comb begin
    cp0_wd    = '0;
    pc_target = '0;
    case (r_state)
      ST_SAVE:    cp0_wd    = r_epc_q;
      ST_MASK:    cp0_wd    = status & 32'hFFFF_FFFE;
      ST_RESTORE: cp0_wd    = status | 32'h0000_0001;
      ST_VECTOR:  pc_target = iv ? VEC1 : VEC0;
      ST_RETURN:  pc_target = epc;
      default: begin
        cp0_wd    = '0;
        pc_target = '0;
      end
    endcase
  end

  assign hold       = r_ctrl.hold;
  assign cp0_we     = r_ctrl.cp0_we;
  assign cp0_addr   = r_ctrl.cp0_addr;
  assign pc_load    = r_ctrl.pc_load;
  assign in_handler = r_ctrl.in_handler;
  assign exc_code   = r_code;

endmodule
`default_nettype wire

// File: tb/tb_exc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_sequencer
//  Description : Self-checking bench for exc_sequencer. The driver issues
//                entries/returns and pushes the expected CP0 writes and PC
//                redirects (with their expected cycle) into a queue; a
//                monitor pops and compares whenever the DUT writes or loads.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exc_sequencer;

  logic        clk;
  logic        rst;
  logic        exl;
  logic        iv;
  logic [7:0]  cause;
  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] pcp4;
  logic        instr_done;
  logic        eret;
  logic        hold;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wd;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        in_handler;
  logic [4:0]  exc_code;

  exc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .exl        (exl),
    .iv         (iv),
    .cause      (cause),
    .status     (status),
    .epc        (epc),
    .pcp4       (pcp4),
    .instr_done (instr_done),
    .eret       (eret),
    .hold       (hold),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wd     (cp0_wd),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .in_handler (in_handler),
    .exc_code   (exc_code)
  );

  typedef struct {
    bit          is_pc;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t q[$];
  int  cyc    = 0;
  int  ntests = 0;
  int  nfail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitor ----------------
  task automatic check_ev(input bit is_pc, input logic [4:0] a, input logic [31:0] d);
    ev_t e;
    ntests++;
    if (q.size() == 0) begin
      nfail++;
      $display("FAIL unexpected_%s: got addr=%0d data=%h at cyc %0d, required none",
               is_pc ? "pc_load" : "cp0_we", a, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.is_pc != is_pc || (!is_pc && e.addr != a) || e.data != d ||
          e.cyc != cyc || hold != !is_pc) begin
        nfail++;
        $display("FAIL event: got pc=%0d addr=%0d data=%h cyc=%0d hold=%0d, required pc=%0d addr=%0d data=%h cyc=%0d hold=%0d",
                 is_pc, a, d, cyc, hold, e.is_pc, e.addr, e.data, e.cyc, !e.is_pc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (cp0_we)  check_ev(1'b0, cp0_addr, cp0_wd);
      if (pc_load) check_ev(1'b1, 5'd0, pc_target);
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [4:0] model_code(input logic [7:0] c);
    if (c[7:2] != 6'd0)      return 5'd0;
    else if (c[1:0] != 2'd0) return 5'd13;
    else                     return 5'd10;
  endfunction

  function automatic logic [31:0] model_vec(input logic v);
    return v ? 32'h0000_0200 : 32'h0000_0180;
  endfunction

  task automatic push_ev(input bit is_pc, input logic [4:0] a, input logic [31:0] d, input int c);
    ev_t e;
    e.is_pc = is_pc;
    e.addr  = a;
    e.data  = d;
    e.cyc   = c;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_hold"},       {31'd0, hold},       32'd0);
    chk({tag, "_cp0_we"},     {31'd0, cp0_we},     32'd0);
    chk({tag, "_pc_load"},    {31'd0, pc_load},    32'd0);
    chk({tag, "_in_handler"}, {31'd0, in_handler}, 32'd0);
    chk({tag, "_cp0_wd"},     cp0_wd,              32'd0);
    chk({tag, "_pc_target"},  pc_target,           32'd0);
  endtask

  // Exception entry with 'drain' cycles waiting for a boundary.
  task automatic do_entry(input logic [7:0] c, input logic v, input logic [31:0] pc4,
                          input logic [31:0] st, input int drain);
    int t;
    cause = c; iv = v; status = st; exl = 1'b1; eret = 1'b0;
    for (int d = 0; d < drain; d++) begin
      instr_done = 1'b0;
      step();
      chk("drain_hold", {31'd0, hold}, 32'd1);
    end
    instr_done = 1'b1;
    pcp4 = pc4;
    t = cyc;
    push_ev(1'b0, 5'd14, pc4, t + 1);
    push_ev(1'b0, 5'd12, st & 32'hFFFF_FFFE, t + 2);
    push_ev(1'b1, 5'd0, model_vec(v), t + 3);
    step();
    instr_done = 1'b0;
    exl = 1'b0;
    pcp4 = $urandom;
    cause = 8'($urandom);  // changes after latch must not affect the code
    step(); step(); step();
    chk("entry_in_handler", {31'd0, in_handler}, 32'd1);
    chk("entry_hold_low", {31'd0, hold}, 32'd0);
    chk("entry_exc_code", {27'd0, exc_code}, {27'd0, model_code(c)});
  endtask

  // Handler activity: stray exl and unqualified eret must be ignored.
  task automatic do_handler(input int n);
    for (int i = 0; i < n; i++) begin
      exl = 1'($urandom);
      instr_done = 1'($urandom);
      eret = instr_done ? 1'b0 : 1'($urandom);
      step();
    end
    exl = 1'b0; instr_done = 1'b0; eret = 1'b0;
    chk("handler_stays", {31'd0, in_handler}, 32'd1);
  endtask

  task automatic do_return(input logic [31:0] ep, input logic [31:0] st);
    int t;
    epc = ep; status = st; eret = 1'b1; instr_done = 1'b1;
    t = cyc;
    push_ev(1'b0, 5'd12, st | 32'h1, t + 1);
    push_ev(1'b1, 5'd0, ep, t + 2);
    step();
    eret = 1'b0; instr_done = 1'b0;
    step(); step();
    chk("return_in_handler", {31'd0, in_handler}, 32'd0);
    chk("return_hold", {31'd0, hold}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rst = 1'b0; exl = 1'b0; iv = 1'b0; cause = '0; status = '0; epc = '0;
    pcp4 = '0; instr_done = 1'b0; eret = 1'b0;
    step(); step();
    chk_idle_outputs("reset");
    chk("reset_exc_code", {27'd0, exc_code}, 32'd0);
    rst = 1'b1;
    step();

    // Interrupt at a boundary
    do_entry(8'h04, 1'b0, 32'h0000_0040, 32'h0000_FF03, 0);
    // ERET with EPC 0x88
    do_return(32'h0000_0088, 32'h0000_FF02);

    // Trap mid-instruction, three drain cycles, vector 1
    do_entry(8'h01, 1'b1, 32'h0000_1004, 32'h1234_5679, 3);
    do_handler(4);
    do_return(32'h0000_1004, 32'h1234_5678);

    // Default code (no cause bits)
    do_entry(8'h00, 1'b0, 32'hABCD_0010, 32'hFFFF_FFFF, 1);
    do_return(32'hABCD_0010, 32'hFFFF_FFFE);

    // Spurious request: one-cycle exl without a boundary
    exl = 1'b1; instr_done = 1'b0;
    step();
    chk("spurious_drain_hold", {31'd0, hold}, 32'd1);
    exl = 1'b0;
    step();
    chk("spurious_idle_hold", {31'd0, hold}, 32'd0);
    step();

    // Ignored eret in IDLE
    eret = 1'b1; instr_done = 1'b1;
    step();
    eret = 1'b0; instr_done = 1'b0;
    step();
    chk_idle_outputs("eret_idle");

    // Reset mid-MASK
    cause = 8'h02; iv = 1'b0; status = 32'h0000_0055; pcp4 = 32'h0000_0300;
    exl = 1'b1; instr_done = 1'b1;
    t = cyc;
    push_ev(1'b0, 5'd14, 32'h0000_0300, t + 1);
    step();
    exl = 1'b0; instr_done = 1'b0;
    step();                       // now in MASK, before the monitor edge
    rst = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    chk("async_reset_exc_code", {27'd0, exc_code}, 32'd0);
    step(); step();
    rst = 1'b1;
    step(); step(); step();
    chk_idle_outputs("post_reset");

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  rc;
      logic [31:0] rs;
      rc = 8'($urandom);
      case ($urandom_range(0, 2))
        0: rc = rc & 8'h03;
        1: rc = 8'h00;
        default: ;
      endcase
      rs = $urandom;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        eret = 1'($urandom); instr_done = 1'($urandom); exl = 1'b0;
        step();
      end
      do_entry(rc, 1'($urandom), $urandom, rs, $urandom_range(0, 3));
      do_handler($urandom_range(0, 5));
      do_return($urandom, $urandom);
    end

    step(); step();
    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
